// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard over the
// open-drain PS/2 clock/data lines and reports device ACK, NACK or timeout.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       error
);

    localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        XFER,
        ACKS,
        WAITREL
    } state_t;

    state_t           state;
    logic [INH_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;
    logic [3:0]       bitcnt;
    logic [7:0]       shreg;
    logic             parity;
    logic             ack_r;

    logic [1:0] clk_sync;
    logic [1:0] data_sync;
    logic       clk_prev;
    logic       fall;
    logic       tmo_expired;

    // Idle PS/2 lines float high, so the synchronizers reset to 1 to avoid a false fall.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], ps2_clk_in};
            data_sync <= {data_sync[0], ps2_data_in};
            clk_prev  <= clk_sync[1];
        end
    end

    assign fall        = clk_prev & ~clk_sync[1];
    assign tmo_expired = ~fall & (tmo == TMO_LAST);

    assign tx_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state       <= IDLE;
            cnt         <= '0;
            tmo         <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            parity      <= 1'b0;
            ack_r       <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_ok      <= 1'b0;
            error       <= 1'b0;
        end else begin
            done   <= 1'b0;
            ack_ok <= 1'b0;
            error  <= 1'b0;

            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid) begin
                        shreg      <= tx_data;
                        parity     <= ~^tx_data;
                        cnt        <= '0;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    ps2_clk_oe <= 1'b1;
                    if (cnt == INH_LAST) begin
                        cnt         <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= REQ;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                REQ: begin
                    ps2_clk_oe <= 1'b0;
                    bitcnt     <= '0;
                    tmo        <= '0;
                    state      <= XFER;
                end

                XFER: begin
                    if (tmo_expired) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        error       <= 1'b1;
                        tmo         <= '0;
                        state       <= IDLE;
                    end else if (fall) begin
                        tmo <= '0;
                        // Host updates data on each device falling edge; the 11th fall is the ACK slot.
                        if (bitcnt < 4'd8) begin
                            ps2_data_oe <= ~shreg[bitcnt[2:0]];
                            bitcnt      <= bitcnt + 1'b1;
                        end else if (bitcnt == 4'd8) begin
                            ps2_data_oe <= ~parity;
                            bitcnt      <= bitcnt + 1'b1;
                        end else if (bitcnt == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                            bitcnt      <= bitcnt + 1'b1;
                        end else begin
                            ack_r <= ~data_sync[1];
                            state <= ACKS;
                        end
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end

                ACKS: begin
                    if (tmo_expired) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        error       <= 1'b1;
                        tmo         <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo   <= fall ? '0 : tmo + 1'b1;
                        state <= WAITREL;
                    end
                end

                WAITREL: begin
                    if (clk_sync[1] && data_sync[1]) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        ack_ok      <= ack_r;
                        tmo         <= '0;
                        state       <= IDLE;
                    end else if (tmo_expired) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        done        <= 1'b1;
                        error       <= 1'b1;
                        tmo         <= '0;
                        state       <= IDLE;
                    end else begin
                        tmo <= fall ? '0 : tmo + 1'b1;
                    end
                end

                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
